// File: rtl/or_bus_event_counter_if.sv
// Snapshot handshake between the event counter (slave) and a slower reader (master).
// The reader drives req/ack and receives a registered copy of the count.
interface or_bus_event_counter_if #(
  parameter int CounterBits = 8
);
  logic                   snap_req;
  logic                   snap_ack;
  logic                   snap_valid;
  logic [CounterBits-1:0] snap_data;

  modport master (output snap_req, output snap_ack, input snap_valid, input snap_data);
  modport slave  (input snap_req, input snap_ack, output snap_valid, output snap_data);
endinterface

// File: rtl/or_bus_event_counter.sv
// Counts tick-qualified rising edges on an OR-bus vector, with sticky overflow and a req/ack snapshot.
// Define OR_BUS_EVENT_COUNTER_SATURATE_EN to make the counter saturate at all-ones instead of wrapping.
module or_bus_event_counter #(
  parameter int NrOfBits    = 1,
  parameter int CounterBits = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic [NrOfBits-1:0]    data_in,
  input  logic                   clear,
  output logic                   event_out,
  output logic [CounterBits-1:0] count_out,
  output logic                   overflow,
  or_bus_event_counter_if.slave  snap
);

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_e;

  localparam logic [CounterBits-1:0] CountMax = '1;

  logic [NrOfBits-1:0] prev;
  logic                hit;
  snap_state_e         snap_state;
  snap_state_e         snap_state_next;

  // Several bits rising together still make a single event.
  assign hit = tick & (|(data_in & ~prev));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev      <= '0;
      event_out <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      if (tick) begin
        prev <= data_in;
      end
      event_out <= hit;
      if (clear) begin
        count_out <= '0;
        overflow  <= 1'b0;
      end else if (hit) begin
        if (count_out == CountMax) begin
`ifdef OR_BUS_EVENT_COUNTER_SATURATE_EN
          count_out <= CountMax;
`else
          count_out <= '0;
`endif
          overflow  <= 1'b1;
        end else begin
          count_out <= count_out + CounterBits'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      snap_state <= SNAP_IDLE;
    end else begin
      snap_state <= snap_state_next;
    end
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    snap_state_next = snap_state;
    unique case (snap_state)
      SNAP_IDLE: if (snap.snap_req) snap_state_next = SNAP_HOLD;
      SNAP_HOLD: if (snap.snap_ack) snap_state_next = SNAP_IDLE;
      default:   snap_state_next = SNAP_IDLE;
    endcase
  end

  always_comb begin
    snap.snap_valid = (snap_state == SNAP_HOLD);
  end

  // Capture the pre-update count, so a same-cycle clear still yields the old value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      snap.snap_data <= '0;
    end else if (snap_state == SNAP_IDLE && snap.snap_req) begin
      snap.snap_data <= count_out;
    end
  end

endmodule

// File: tb/tb_or_bus_event_counter.sv
// Scoreboard bench for or_bus_event_counter with NrOfBits=4, CounterBits=4.
// Expected outputs are pushed when stimulus is driven and popped after the clock edge.
module tb_or_bus_event_counter;

  localparam int NB = 4;
  localparam int CB = 4;
`ifdef OR_BUS_EVENT_COUNTER_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct packed {
    logic          ev;
    logic [CB-1:0] count;
    logic          ovf;
    logic          valid;
    logic [CB-1:0] sdata;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic          clear = 1'b0;
  logic          event_out;
  logic [CB-1:0] count_out;
  logic          overflow;

  or_bus_event_counter_if #(.CounterBits(CB)) snap_bus ();

  or_bus_event_counter #(.NrOfBits(NB), .CounterBits(CB)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .tick     (tick),
    .data_in  (data_in),
    .clear    (clear),
    .event_out(event_out),
    .count_out(count_out),
    .overflow (overflow),
    .snap     (snap_bus.slave)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [NB-1:0] m_prev = '0;
  logic [CB-1:0] m_count = '0;
  logic          m_ovf = 1'b0;
  logic          m_valid = 1'b0;
  logic [CB-1:0] m_sdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic tk, input logic [NB-1:0] d,
                      input logic clr, input logic rq, input logic ak);
    exp_t e;
    logic hit;
    @(negedge clock);
    reset_n           = rst;
    tick              = tk;
    data_in           = d;
    clear             = clr;
    snap_bus.snap_req = rq;
    snap_bus.snap_ack = ak;

    if (!rst) begin
      m_prev = '0; m_count = '0; m_ovf = 1'b0; m_valid = 1'b0; m_sdata = '0;
      hit = 1'b0;
    end else begin
      hit = tk && ((d & ~m_prev) != '0);
      if (!m_valid && rq) m_sdata = m_count;
      m_valid = m_valid ? !ak : rq;
      if (clr) begin
        m_count = '0;
        m_ovf   = 1'b0;
      end else if (hit) begin
        if (m_count == {CB{1'b1}}) begin
          m_count = Sat ? {CB{1'b1}} : '0;
          m_ovf   = 1'b1;
        end else begin
          m_count = m_count + 1'b1;
        end
      end
      if (tk) m_prev = d;
    end
    e.ev = hit; e.count = m_count; e.ovf = m_ovf; e.valid = m_valid; e.sdata = m_sdata;
    exp_q.push_back(e);

    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("event_out",  32'(event_out),          32'(e.ev));
    check("count_out",  32'(count_out),          32'(e.count));
    check("overflow",   32'(overflow),           32'(e.ovf));
    check("snap_valid", 32'(snap_bus.snap_valid), 32'(e.valid));
    check("snap_data",  32'(snap_bus.snap_data),  32'(e.sdata));
  endtask

  // One rising edge on bit 0: low sample, then high sample.
  task automatic pulse_event();
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    snap_bus.snap_req = 1'b0;
    snap_bus.snap_ack = 1'b0;

    // Reset, then the first edge with bit already high
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("first_event", 32'(event_out), 32'd1);
    check("first_count", 32'(count_out), 32'd1);
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("held_count", 32'(count_out), 32'd1);

    // Multi-bit rise counts once
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    check("multibit_count", 32'(count_out), 32'd2);

    // Tick gating: bit 3 rises while frozen, counted on the first tick cycle
    step(1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);
    check("gated_no_event", 32'(event_out), 32'd0);
    step(1'b1, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
    check("gated_event", 32'(event_out), 32'd1);
    check("gated_count", 32'(count_out), 32'd3);

    // Wrap / saturate from zero after 16 events
    step(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) pulse_event();
    check("wrap_count", 32'(count_out), Sat ? 32'd15 : 32'd0);
    check("wrap_overflow", 32'(overflow), 32'd1);

    // Clear beats a same-cycle event at count 7
    if (Sat) step(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) pulse_event();
    check("pre_clear_count", 32'(count_out), 32'd7);
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    check("clear_event", 32'(event_out), 32'd1);
    check("clear_count", 32'(count_out), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);

    // Snapshot at 5, held through more events and a second request
    for (int i = 0; i < 5; i++) pulse_event();
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    check("snap_valid_up", 32'(snap_bus.snap_valid), 32'd1);
    check("snap_data_5", 32'(snap_bus.snap_data), 32'd5);
    for (int i = 0; i < 3; i++) pulse_event();
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    check("snap_frozen", 32'(snap_bus.snap_data), 32'd5);
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
    check("snap_valid_down", 32'(snap_bus.snap_valid), 32'd0);

    // Request with clear captures pre-clear 9
    pulse_event();
    step(1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0);
    check("snap_preclear", 32'(snap_bus.snap_data), 32'd9);
    check("snap_clear_count", 32'(count_out), 32'd0);
    // Req and ack together in HOLD: back to idle without a new capture
    pulse_event();
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1);
    check("snap_drop_valid", 32'(snap_bus.snap_valid), 32'd0);
    check("snap_drop_data", 32'(snap_bus.snap_data), 32'd9);
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("snap_stay_idle", 32'(snap_bus.snap_valid), 32'd0);
    // Reset in HOLD
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    check("snap_data_1", 32'(snap_bus.snap_data), 32'd1);
    step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("rst_snap_valid", 32'(snap_bus.snap_valid), 32'd0);
    check("rst_snap_data", 32'(snap_bus.snap_data), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 3) != 0), 4'($urandom),
           ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/or_bus_event_counter.md
# or_bus_event_counter

Counts rising-edge events on the combined OR-bus result. It sits directly downstream of the 4-input OR gate bus and consumes its `result` vector: any 0→1 transition on any bit, qualified by `tick`, is one event. The block keeps a running count and a sticky overflow flag. A req/ack snapshot port lets a slower reader capture a stable copy of the count.

## Interface
Parameters:
- `NrOfBits`, 1: width of the monitored OR-bus vector (matches the upstream gate).
- `CounterBits`, 8: width of the event counter and the snapshot register (≥2).

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `tick`  in  1  sample enable; when low, edge detection and counting are frozen.
- `data_in`  in  NrOfBits  OR-bus result from the upstream gate.
- `clear`  in  1  synchronous clear of the counter and the overflow flag.
- `event_out`  out  1  one-cycle pulse per counted event.
- `count_out`  out  CounterBits  current event count.
- `overflow`  out  1  sticky; set when the counter passes its maximum.
- `snap_req`  in  1  request to capture `count_out`.
- `snap_valid`  out  1  snapshot held and valid.
- `snap_data`  out  CounterBits  captured count.
- `snap_ack`  in  1  reader has consumed the snapshot.

## Operation
- The previous-sample register `prev` (NrOfBits) loads `data_in` only in cycles with `tick`=1.
- `rise = data_in & ~prev`. An event is counted when `tick`=1 and `|rise`=1.
- One event is counted per cycle, regardless of how many bits rise together.
- Counter, when an event occurs:
  - If `count_out` < max, then `count_out` + 1.
  - If `count_out` = max, the counter wraps to 0 and `overflow` is set to 1. The saturating variant is under Configuration.
- `clear`=1 sets the counter to 0 and `overflow` to 0, and has priority over a same-cycle event. `event_out` still pulses for that event.
- `prev` is not affected by `clear`.
- Snapshot handshake, two states:
  - IDLE (`snap_valid`=0): `snap_req`=1 loads `snap_data` with the pre-update `count_out` of that cycle and moves to HOLD.
  - HOLD (`snap_valid`=1): `snap_data` is frozen and `snap_req` is ignored. `snap_ack`=1 returns to IDLE.
  - If `snap_req` and `snap_ack` are both high in HOLD, the block returns to IDLE and the request is dropped. The requester re-issues it.
  - `snap_ack` is ignored in IDLE.
- A same-cycle `clear` and `snap_req` capture the pre-clear value.

## Timing
- Reset (`reset_n`=0 at a clock edge) sets:
  - `prev`=0 and `count_out`=0
  - `overflow`=0 and `event_out`=0
  - `snap_valid`=0 and `snap_data`=0
  
  Reset overrides every other input, including mid-handshake.
- Because `prev` resets to 0, a bit already high at the first `tick` after reset counts as an event.
- Edge sampled at clock edge N:
  - `event_out`=1 and `count_out` incremented, both visible after edge N and held for exactly one cycle (for `event_out`).
  - Latency from `data_in` change to outputs is 1 cycle.
- `snap_valid` rises one cycle after the `snap_req` edge. It falls one cycle after the `snap_ack` edge.
- All outputs are registered. There is no combinational path from any input to any output.
- While `tick`=0, `event_out` stays 0, and `count_out` and `prev` hold. `clear` and the snapshot logic remain active.

## Configuration
- Macro `OR_BUS_EVENT_COUNTER_SATURATE_EN`.
- Defined: at max the counter holds at all-ones instead of wrapping. `overflow` is set on the first event that arrives while the count is at max. `event_out` still pulses for that event.
- Undefined: the counter wraps to 0 as described in Operation.

## Test plan
- Reset and first edge: `reset_n` low 2 cycles, then `data_in`=1 with `tick`=1 at cycle 3 → `event_out` pulses at cycle 4 and `count_out`=1; `data_in` held at 1 → no further events.
- Multi-bit and tick gating (`NrOfBits`=4): 0000→0101 → one event (count +1). Toggle bit 3 while `tick`=0, then raise `tick` → edge counted on the first `tick` cycle.
- Wrap (`CounterBits`=4): 16 events from 0 → `count_out`=0 and `overflow`=1. With the macro defined: `count_out`=15 and `overflow`=1.
- Clear priority: event and `clear` in the same cycle with count=7 → `count_out`=0, `overflow`=0, and `event_out` pulses.
- Snapshot: count=5 and `snap_req` → `snap_valid`=1 and `snap_data`=5 next cycle. Three more events leave `snap_data`=5. A new `snap_req` is ignored. `snap_ack` → `snap_valid`=0 next cycle.
- Snapshot corners: `snap_req` with `clear` at count=9 → `snap_data`=9. In HOLD, `snap_req` and `snap_ack` together → IDLE with no new capture. `reset_n` in HOLD → `snap_valid`=0 and `snap_data`=0.
